// File: rtl/light_package.sv
// Shared types for the five-light controller and its intersection model.
// The colors enum is the one the controller already uses; lane indices and
// the conflict matrix let the intersection model reason about lane pairs.
package light_package;

   typedef enum logic [1:0] {
      RED    = 2'b00,
      YELLOW = 2'b01,
      GREEN  = 2'b10
   } colors;

   typedef enum logic [2:0] {
      E_STR  = 3'd0,
      W_STR  = 3'd1,
      E_LEFT = 3'd2,
      W_LEFT = 3'd3,
      NS     = 3'd4
   } lane_idx_t;

   localparam int NUM_LANES = 5;

   // Row i, bit j set means lanes i and j must never be non-red together.
   // North-south conflicts with everything; each straight conflicts with
   // the opposing left turn.
   localparam logic [NUM_LANES-1:0][NUM_LANES-1:0] CONFLICT_MATRIX = {
      5'b01111,   // NS
      5'b10001,   // W_LEFT
      5'b10010,   // E_LEFT
      5'b10100,   // W_STR
      5'b11000    // E_STR
   };

   function automatic logic is_non_red(input colors c);
      return (c != RED);
   endfunction

endpackage

// File: rtl/traffic_intersection_model_lane_queue.sv
// One lane of the intersection: car queue depth, drop-on-full overflow flag,
// and a red-light wait counter that raises a sticky starvation flag.
module lane_queue
   import light_package::*;
#(
   parameter int QMAX         = 15,
   parameter int STARVE_LIMIT = 20,
   localparam int CW          = $clog2(QMAX + 1),
   localparam int WW          = $clog2(STARVE_LIMIT + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          arrive,
   input  colors         light,
   output logic [CW-1:0] count,
   output logic          depart,
   output logic          overflow,
   output logic          starve
);

   logic          arr;
   logic          drop;
   logic          full;
   logic [CW-1:0] count_next;
   logic [WW-1:0] wait_cnt;
   logic [WW-1:0] wait_next;

   // Queue arithmetic: a departure frees a slot, so arrive+depart at full is accepted.
   always_comb begin
      depart     = (light == GREEN) && (count != '0);
      full       = (count == CW'(QMAX));
      arr        = arrive && !(full && !depart);
      drop       = arrive && full && !depart;
      count_next = count;
      if (arr && !depart) begin
         count_next = count + CW'(1);
      end else if (!arr && depart) begin
         count_next = count - CW'(1);
      end
   end

   // Wait counter grows only while cars sit at a red light, saturating at the limit.
   always_comb begin
      wait_next = '0;
      if ((count != '0) && (light == RED)) begin
         if (wait_cnt == WW'(STARVE_LIMIT)) begin
            wait_next = wait_cnt;
         end else begin
            wait_next = wait_cnt + WW'(1);
         end
      end
   end

   // State and sticky flags; starve rises on the same edge the counter hits the limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         wait_cnt <= '0;
         overflow <= 1'b0;
         starve   <= 1'b0;
      end else begin
         count    <= count_next;
         wait_cnt <= wait_next;
         overflow <= overflow | drop;
         starve   <= starve | (wait_next == WW'(STARVE_LIMIT));
      end
   end

endmodule

// File: rtl/traffic_intersection_model.sv
// Closed-loop intersection model: five lane queues fed by arrivals and
// drained by green lights, sensors back to the controller, plus checks for
// conflicting lights and a running count of departed cars.
module traffic_intersection_model
   import light_package::*;
#(
   parameter int QMAX         = 15,
   parameter int STARVE_LIMIT = 20,
   localparam int CW          = $clog2(QMAX + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          e_str_arrive,
   input  logic          w_str_arrive,
   input  logic          e_left_arrive,
   input  logic          w_left_arrive,
   input  logic          ns_arrive,
   input  colors         e_str_light,
   input  colors         w_str_light,
   input  colors         e_left_light,
   input  colors         w_left_light,
   input  colors         ns_light,
   output logic          e_str_sensor,
   output logic          w_str_sensor,
   output logic          e_left_sensor,
   output logic          w_left_sensor,
   output logic          ns_sensor,
   output logic [CW-1:0] e_str_count,
   output logic [CW-1:0] w_str_count,
   output logic [CW-1:0] e_left_count,
   output logic [CW-1:0] w_left_count,
   output logic [CW-1:0] ns_count,
   output logic [15:0]   served_total,
   output logic          conflict,
   output logic [4:0]    overflow,
   output logic [4:0]    starve
);

   logic [NUM_LANES-1:0] lane_arrive;
   colors                lane_light [NUM_LANES];
   logic [CW-1:0]        lane_count [NUM_LANES];
   logic [NUM_LANES-1:0] lane_depart;
   logic [NUM_LANES-1:0] lane_non_red;
   logic [2:0]           dep_sum;
   logic                 conflict_now;

   assign lane_arrive = {ns_arrive, w_left_arrive, e_left_arrive, w_str_arrive, e_str_arrive};

   assign lane_light[E_STR]  = e_str_light;
   assign lane_light[W_STR]  = w_str_light;
   assign lane_light[E_LEFT] = e_left_light;
   assign lane_light[W_LEFT] = w_left_light;
   assign lane_light[NS]     = ns_light;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lane_queue #(
         .QMAX         (QMAX),
         .STARVE_LIMIT (STARVE_LIMIT)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .arrive   (lane_arrive[i]),
         .light    (lane_light[i]),
         .count    (lane_count[i]),
         .depart   (lane_depart[i]),
         .overflow (overflow[i]),
         .starve   (starve[i])
      );
      assign lane_non_red[i] = is_non_red(lane_light[i]);
   end

   assign e_str_count   = lane_count[E_STR];
   assign w_str_count   = lane_count[W_STR];
   assign e_left_count  = lane_count[E_LEFT];
   assign w_left_count  = lane_count[W_LEFT];
   assign ns_count      = lane_count[NS];

   assign e_str_sensor  = (lane_count[E_STR]  != '0);
   assign w_str_sensor  = (lane_count[W_STR]  != '0);
   assign e_left_sensor = (lane_count[E_LEFT] != '0);
   assign w_left_sensor = (lane_count[W_LEFT] != '0);
   assign ns_sensor     = (lane_count[NS]     != '0);

   // Scan every lane pair against the conflict matrix and count departures this cycle.
   always_comb begin
      conflict_now = 1'b0;
      dep_sum      = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         dep_sum = dep_sum + 3'(lane_depart[i]);
         for (int j = 0; j < NUM_LANES; j++) begin
            if (CONFLICT_MATRIX[i][j] && lane_non_red[i] && lane_non_red[j]) begin
               conflict_now = 1'b1;
            end
         end
      end
   end

   // Sticky conflict flag and the wrapping served-car total.
   always_ff @(posedge clk) begin
      if (reset) begin
         conflict     <= 1'b0;
         served_total <= '0;
      end else begin
         conflict     <= conflict | conflict_now;
         served_total <= served_total + 16'(dep_sum);
      end
   end

endmodule

// File: tb/tb_traffic_intersection_model.sv
// Directed bench for the intersection model: each task drives one scenario
// and compares outputs against hand-computed values.
module tb_traffic_intersection_model;
   import light_package::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        e_str_arrive, w_str_arrive, e_left_arrive, w_left_arrive, ns_arrive;
   colors       e_str_light, w_str_light, e_left_light, w_left_light, ns_light;
   logic        e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor;
   logic [3:0]  e_str_count, w_str_count, e_left_count, w_left_count, ns_count;
   logic [15:0] served_total;
   logic        conflict;
   logic [4:0]  overflow;
   logic [4:0]  starve;

   int errors = 0;
   int checks = 0;

   traffic_intersection_model #(.QMAX(15), .STARVE_LIMIT(20)) dut (
      .clk           (clk),
      .reset         (reset),
      .e_str_arrive  (e_str_arrive),
      .w_str_arrive  (w_str_arrive),
      .e_left_arrive (e_left_arrive),
      .w_left_arrive (w_left_arrive),
      .ns_arrive     (ns_arrive),
      .e_str_light   (e_str_light),
      .w_str_light   (w_str_light),
      .e_left_light  (e_left_light),
      .w_left_light  (w_left_light),
      .ns_light      (ns_light),
      .e_str_sensor  (e_str_sensor),
      .w_str_sensor  (w_str_sensor),
      .e_left_sensor (e_left_sensor),
      .w_left_sensor (w_left_sensor),
      .ns_sensor     (ns_sensor),
      .e_str_count   (e_str_count),
      .w_str_count   (w_str_count),
      .e_left_count  (e_left_count),
      .w_left_count  (w_left_count),
      .ns_count      (ns_count),
      .served_total  (served_total),
      .conflict      (conflict),
      .overflow      (overflow),
      .starve        (starve)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic all_idle();
      e_str_arrive = 0; w_str_arrive = 0; e_left_arrive = 0; w_left_arrive = 0; ns_arrive = 0;
      e_str_light = RED; w_str_light = RED; e_left_light = RED; w_left_light = RED; ns_light = RED;
   endtask

   task automatic test_reset();
      all_idle();
      reset = 1;
      step();
      step();
      reset = 0;
      checks++;
      if ({e_str_count, w_str_count, e_left_count, w_left_count, ns_count} !== 20'd0) begin
         errors++; $display("[TB] FAIL reset_counts got=%h want=0", {e_str_count, w_str_count, e_left_count, w_left_count, ns_count});
      end
      checks++;
      if ({e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor} !== 5'd0) begin
         errors++; $display("[TB] FAIL reset_sensors got=%b want=00000", {e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor});
      end
      checks++;
      if (served_total !== 16'd0 || conflict !== 1'b0 || overflow !== 5'd0 || starve !== 5'd0) begin
         errors++; $display("[TB] FAIL reset_flags got served=%0d conflict=%b overflow=%b starve=%b want all 0", served_total, conflict, overflow, starve);
      end
   endtask

   task automatic test_arrival();
      e_str_arrive = 1;
      step();
      checks++;
      if (e_str_count !== 4'd1 || e_str_sensor !== 1'b1) begin
         errors++; $display("[TB] FAIL arrival_latency got count=%0d sensor=%b want count=1 sensor=1", e_str_count, e_str_sensor);
      end
      step();
      step();
      e_str_arrive = 0;
      checks++;
      if (e_str_count !== 4'd3 || e_str_sensor !== 1'b1) begin
         errors++; $display("[TB] FAIL arrival_three got count=%0d sensor=%b want count=3 sensor=1", e_str_count, e_str_sensor);
      end
      checks++;
      if ({w_str_count, e_left_count, w_left_count, ns_count} !== 16'd0 || {w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor} !== 4'd0) begin
         errors++; $display("[TB] FAIL arrival_other_lanes got counts=%h want=0", {w_str_count, e_left_count, w_left_count, ns_count});
      end
      checks++;
      if (served_total !== 16'd0) begin
         errors++; $display("[TB] FAIL arrival_served got=%0d want=0", served_total);
      end
   endtask

   task automatic test_drain();
      logic [3:0] exp_count [5] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
      e_str_light = GREEN;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (e_str_count !== exp_count[i] || e_str_sensor !== (exp_count[i] != 4'd0)) begin
            errors++; $display("[TB] FAIL drain_edge%0d got count=%0d sensor=%b want count=%0d", i + 1, e_str_count, e_str_sensor, exp_count[i]);
         end
      end
      e_str_light = RED;
      checks++;
      if (served_total !== 16'd3) begin
         errors++; $display("[TB] FAIL drain_served got=%0d want=3", served_total);
      end
   endtask

   task automatic test_overflow();
      w_left_arrive = 1;
      for (int i = 0; i < 15; i++) step();
      checks++;
      if (w_left_count !== 4'd15 || overflow !== 5'b00000) begin
         errors++; $display("[TB] FAIL overflow_fill got count=%0d overflow=%b want count=15 overflow=00000", w_left_count, overflow);
      end
      step();
      checks++;
      if (w_left_count !== 4'd15 || overflow !== 5'b01000) begin
         errors++; $display("[TB] FAIL overflow_drop got count=%0d overflow=%b want count=15 overflow=01000", w_left_count, overflow);
      end
      w_left_light = GREEN;
      step();
      checks++;
      if (w_left_count !== 4'd15 || overflow !== 5'b01000 || served_total !== 16'd4) begin
         errors++; $display("[TB] FAIL overflow_arrive_depart got count=%0d overflow=%b served=%0d want 15 01000 4", w_left_count, overflow, served_total);
      end
      w_left_arrive = 0;
      for (int i = 0; i < 15; i++) step();
      w_left_light = RED;
      checks++;
      if (w_left_count !== 4'd0 || served_total !== 16'd19 || starve !== 5'd0) begin
         errors++; $display("[TB] FAIL overflow_drain got count=%0d served=%0d starve=%b want 0 19 00000", w_left_count, served_total, starve);
      end
   endtask

   task automatic test_conflict();
      e_str_light = GREEN; w_str_light = GREEN;
      step();
      e_str_light = GREEN; w_str_light = RED; e_left_light = GREEN;
      step();
      all_idle();
      step();
      checks++;
      if (conflict !== 1'b0) begin
         errors++; $display("[TB] FAIL conflict_allowed_pairs got=%b want=0", conflict);
      end
      ns_light = YELLOW; e_left_light = GREEN;
      step();
      all_idle();
      checks++;
      if (conflict !== 1'b1) begin
         errors++; $display("[TB] FAIL conflict_set got=%b want=1", conflict);
      end
      step();
      step();
      checks++;
      if (conflict !== 1'b1) begin
         errors++; $display("[TB] FAIL conflict_sticky got=%b want=1", conflict);
      end
   endtask

   task automatic test_starve();
      ns_arrive = 1;
      step();
      ns_arrive = 0;
      checks++;
      if (ns_count !== 4'd1 || ns_sensor !== 1'b1) begin
         errors++; $display("[TB] FAIL starve_setup got count=%0d sensor=%b want 1 1", ns_count, ns_sensor);
      end
      for (int i = 0; i < 19; i++) step();
      checks++;
      if (starve !== 5'b00000) begin
         errors++; $display("[TB] FAIL starve_at_19 got=%b want=00000", starve);
      end
      step();
      checks++;
      if (starve !== 5'b10000) begin
         errors++; $display("[TB] FAIL starve_at_20 got=%b want=10000", starve);
      end
   endtask

   task automatic test_reset_mid();
      e_str_arrive = 1;
      step();
      step();
      e_str_arrive = 0;
      e_str_light = GREEN;
      step();
      checks++;
      if (e_str_count !== 4'd1 || ns_count !== 4'd1) begin
         errors++; $display("[TB] FAIL reset_mid_setup got e_str=%0d ns=%0d want 1 1", e_str_count, ns_count);
      end
      reset = 1;
      e_str_arrive = 1; w_str_arrive = 1; e_left_arrive = 1; w_left_arrive = 1; ns_arrive = 1;
      ns_light = GREEN; w_left_light = GREEN;
      step();
      checks++;
      if ({e_str_count, w_str_count, e_left_count, w_left_count, ns_count} !== 20'd0 ||
          {e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor} !== 5'd0) begin
         errors++; $display("[TB] FAIL reset_mid_counts got=%h want=0", {e_str_count, w_str_count, e_left_count, w_left_count, ns_count});
      end
      checks++;
      if (served_total !== 16'd0 || conflict !== 1'b0 || overflow !== 5'd0 || starve !== 5'd0) begin
         errors++; $display("[TB] FAIL reset_mid_flags got served=%0d conflict=%b overflow=%b starve=%b want all 0", served_total, conflict, overflow, starve);
      end
      reset = 0;
      all_idle();
      w_str_arrive = 1;
      step();
      w_str_arrive = 0;
      checks++;
      if (w_str_count !== 4'd1 || served_total !== 16'd0) begin
         errors++; $display("[TB] FAIL reset_mid_resume got count=%0d served=%0d want 1 0", w_str_count, served_total);
      end
   endtask

   initial begin
      reset = 1;
      all_idle();
      test_reset();
      test_arrival();
      test_drain();
      test_overflow();
      test_conflict();
      test_starve();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
